// File: rtl/pbkdf2_seq_ctrl_if.sv
// Link between the PBKDF2 sequencer and the shared HMAC-SHA256 core.
// The sequencer is the master; the HMAC core is the slave.
interface pbkdf2_seq_ctrl_if;
    localparam int unsigned DATA_W   = 1312;
    localparam int unsigned DIGEST_W = 256;

    logic [DATA_W-1:0]   hmac_data;
    logic                hmac_enable;
    logic [DIGEST_W-1:0] hmac_hash;
    logic                hmac_hash_done;

    modport master (
        output hmac_data,
        output hmac_enable,
        input  hmac_hash,
        input  hmac_hash_done
    );

    modport slave (
        input  hmac_data,
        input  hmac_enable,
        output hmac_hash,
        output hmac_hash_done
    );
endinterface

// File: rtl/pbkdf2_seq_ctrl.sv
// PBKDF2 stage for scrypt that walks one shared HMAC core through block indices
// 1..NUM_BLOCKS and assembles the digests MSB-first into the output hash.
module pbkdf2_seq_ctrl #(
    parameter  int unsigned NUM_BLOCKS     = 4,
    parameter  int unsigned TIMEOUT_CYCLES = 4096,
    localparam int unsigned KEY_W          = 640,
    localparam int unsigned DIGEST_W       = 256,
    localparam int unsigned HASH_W         = NUM_BLOCKS * DIGEST_W
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [KEY_W-1:0]    pass,
    input  logic [KEY_W-1:0]    salt,
    output logic                busy,
    output logic [HASH_W-1:0]   hash,
    output logic                hash_done,
    output logic                err,
    pbkdf2_seq_ctrl_if.master   hmac
);
    localparam int unsigned DATA_W = 2 * KEY_W + 32;
    localparam int unsigned BLK_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NUM_BLOCKS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    logic [2:0]        state,     state_nxt;
    logic [KEY_W-1:0]  pass_q,    pass_q_nxt;
    logic [KEY_W-1:0]  salt_q,    salt_q_nxt;
    logic [BLK_W-1:0]  blk,       blk_nxt;
    logic [TMO_W-1:0]  tmo_cnt,   tmo_nxt;
    logic [HASH_W-1:0] hash_nxt;
    logic              busy_nxt;
    logic              hash_done_nxt;
    logic              err_nxt;
    logic              enable_nxt;
    logic [DATA_W-1:0] data_nxt;

    // State and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state            <= S_IDLE;
            pass_q           <= '0;
            salt_q           <= '0;
            blk              <= '0;
            tmo_cnt          <= '0;
            hash             <= '0;
            busy             <= 1'b0;
            hash_done        <= 1'b0;
            err              <= 1'b0;
            hmac.hmac_enable <= 1'b0;
            hmac.hmac_data   <= '0;
        end else begin
            state            <= state_nxt;
            pass_q           <= pass_q_nxt;
            salt_q           <= salt_q_nxt;
            blk              <= blk_nxt;
            tmo_cnt          <= tmo_nxt;
            hash             <= hash_nxt;
            busy             <= busy_nxt;
            hash_done        <= hash_done_nxt;
            err              <= err_nxt;
            hmac.hmac_enable <= enable_nxt;
            hmac.hmac_data   <= data_nxt;
        end
    end

    // Next state; enable and busy are recomputed every cycle, the rest hold by default
    always_comb begin
        state_nxt     = state;
        pass_q_nxt    = pass_q;
        salt_q_nxt    = salt_q;
        blk_nxt       = blk;
        tmo_nxt       = tmo_cnt;
        hash_nxt      = hash;
        hash_done_nxt = hash_done;
        err_nxt       = err;
        busy_nxt      = 1'b0;
        enable_nxt    = 1'b0;
        data_nxt      = hmac.hmac_data;

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    // Core data is built from the live inputs since pass_q/salt_q load on this edge
                    state_nxt     = S_RUN;
                    pass_q_nxt    = pass;
                    salt_q_nxt    = salt;
                    blk_nxt       = '0;
                    tmo_nxt       = '0;
                    hash_nxt      = '0;
                    hash_done_nxt = 1'b0;
                    err_nxt       = 1'b0;
                    busy_nxt      = 1'b1;
                    enable_nxt    = 1'b1;
                    data_nxt      = {pass, salt, 32'd1};
                end
            end

            S_RUN: begin
                busy_nxt = 1'b1;
                if (hmac.hmac_hash_done) begin
                    for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
                        if (BLK_W'(i) == blk) begin
                            hash_nxt[HASH_W-1-DIGEST_W*i -: DIGEST_W] = hmac.hmac_hash;
                        end
                    end
                    if (blk == BLK_LAST) begin
                        state_nxt     = S_DONE;
                        hash_done_nxt = 1'b1;
                        busy_nxt      = 1'b0;
                    end else begin
                        blk_nxt   = blk + BLK_W'(1);
                        state_nxt = S_GAP;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = S_ERROR;
                    err_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    tmo_nxt    = tmo_cnt + TMO_W'(1);
                    enable_nxt = 1'b1;
                end
            end

            // One cycle with enable low so the core restarts on the next index
            S_GAP: begin
                state_nxt  = S_RUN;
                busy_nxt   = 1'b1;
                enable_nxt = 1'b1;
                tmo_nxt    = '0;
                data_nxt   = {pass_q, salt_q, 32'(blk) + 32'd1};
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_pbkdf2_seq_ctrl.sv
// Randomised scoreboard bench for pbkdf2_seq_ctrl with a behavioural HMAC core
// whose per-index latency and digest are chosen by the stimulus.
module tb_pbkdf2_seq_ctrl;
    localparam int NB   = 4;
    localparam int TMO  = 16;
    localparam int HANG = 1000000;

    typedef struct {
        logic [1023:0] hash;
        int            cyc;
        bit            is_err;
    } exp_t;

    logic           clk = 1'b0;
    logic           n_rst = 1'b0;
    logic           start = 1'b0;
    logic [639:0]   pass = '0;
    logic [639:0]   salt = '0;
    logic           busy;
    logic [1023:0]  hash;
    logic           hash_done;
    logic           err;

    pbkdf2_seq_ctrl_if hif ();

    pbkdf2_seq_ctrl #(.NUM_BLOCKS(NB), .TIMEOUT_CYCLES(TMO)) u_dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .pass      (pass),
        .salt      (salt),
        .busy      (busy),
        .hash      (hash),
        .hash_done (hash_done),
        .err       (err),
        .hmac      (hif)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Stand-in for the HMAC digest: folds the whole message down to 256 bits
    function automatic logic [255:0] core_f(input logic [1311:0] d);
        logic [255:0] acc;
        acc = d[1311:1056] ^ d[1055:800] ^ d[799:544] ^ d[543:288] ^ d[287:32];
        acc = acc ^ {8{d[31:0] * 32'h9E37_79B9}};
        return acc;
    endfunction

    function automatic logic [639:0] rand640();
        logic [639:0] r;
        for (int i = 0; i < 20; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Expected result of one derivation, from block latencies alone
    function automatic exp_t model(input logic [639:0] p, input logic [639:0] s,
                                   input int l0, input int l1, input int l2, input int l3,
                                   input int t);
        exp_t r;
        int   lat [4];
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
        r.hash   = '0;
        r.is_err = 1'b0;
        r.cyc    = t + 1;
        for (int b = 0; b < NB; b++) begin
            if (lat[b] > TMO - 1) begin
                r.cyc    = r.cyc + TMO;
                r.is_err = 1'b1;
                break;
            end
            r.hash[1023-256*b -: 256] = core_f({p, s, 32'(b + 1)});
            r.cyc = r.cyc + lat[b] + 1 + ((b < NB - 1) ? 1 : 0);
        end
        return r;
    endfunction

    // Behavioural core: done after lat_arr[idx-1] enabled cycles; spur forces a stray done
    int   lat_arr [4];
    int   en_cnt = 0;
    logic spur = 1'b0;
    logic [1:0] li;

    always @(posedge clk) en_cnt <= hif.hmac_enable ? en_cnt + 1 : 0;

    always_comb begin
        li = hif.hmac_data[1:0] - 2'd1;
        hif.hmac_hash_done = spur;
        hif.hmac_hash      = spur ? ~core_f(hif.hmac_data) : core_f(hif.hmac_data);
        if (hif.hmac_enable && hif.hmac_data[31:0] >= 32'd1 && hif.hmac_data[31:0] <= 32'd4
            && en_cnt == lat_arr[li])
            hif.hmac_hash_done = 1'b1;
    end

    exp_t          sbq [$];
    logic [639:0]  cur_pass = '0;
    logic [639:0]  cur_salt = '0;
    int            last_evt_cyc = 0;
    logic [1023:0] last_exp_hash = '0;

    // Monitor: pops the scoreboard on each rising hash_done/err, checks core data while enabled
    initial begin
        logic prev_done = 1'b0;
        logic prev_err  = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (n_rst) begin
                if ((hash_done && !prev_done) || (err && !prev_err)) begin
                    last_evt_cyc = cyc;
                    if (sbq.size() == 0) begin
                        chk("unexpected_completion", 256'(cyc), 256'(0));
                    end else begin
                        e = sbq.pop_front();
                        last_exp_hash = e.hash;
                        chk("completion_cycle", 256'(cyc), 256'(e.cyc));
                        chk("err_flag", 256'(err), 256'(e.is_err));
                        chk("hash_done_flag", 256'(hash_done), 256'(!e.is_err));
                        chk("busy_at_end", 256'(busy), 256'(0));
                        chk("enable_at_end", 256'(hif.hmac_enable), 256'(0));
                        for (int b = 0; b < NB; b++)
                            chk($sformatf("hash_slot%0d", b), hash[1023-256*b -: 256],
                                e.hash[1023-256*b -: 256]);
                    end
                end
                if (hif.hmac_enable)
                    chk("core_data_latched", 256'(hif.hmac_data[1311:32] == {cur_pass, cur_salt}),
                        256'(1));
            end
            prev_done = hash_done;
            prev_err  = err;
        end
    end

    // Accepted start: pushes the expectation, then checks the cleared outputs
    task automatic do_start(input logic [639:0] p, input logic [639:0] s,
                            input int l0, input int l1, input int l2, input int l3,
                            output int t);
        @(posedge clk);
        #1;
        lat_arr[0] = l0; lat_arr[1] = l1; lat_arr[2] = l2; lat_arr[3] = l3;
        pass = p; salt = s; start = 1'b1;
        cur_pass = p; cur_salt = s;
        t = cyc;
        sbq.push_back(model(p, s, l0, l1, l2, l3, t));
        @(posedge clk);
        #1;
        start = 1'b0;
        pass  = rand640();
        salt  = rand640();
        @(negedge clk);
        chk("start_busy", 256'(busy), 256'(1));
        chk("start_clears_done", 256'(hash_done), 256'(0));
        chk("start_clears_err", 256'(err), 256'(0));
        chk("start_clears_hash", hash[1023:768] | hash[767:512] | hash[511:256] | hash[255:0], 256'(0));
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk);
            if (sbq.size() == 0 && !busy) break;
        end
        if (k == budget) chk("wait_idle_timeout", 256'(budget), 256'(0));
    endtask

    task automatic wait_block(input int idx);
        int k;
        for (k = 0; k < 500; k++) begin
            @(posedge clk);
            #1;
            if (hif.hmac_enable && hif.hmac_data[31:0] == 32'(idx)) break;
        end
        if (k == 500) chk("wait_block_timeout", 256'(idx), 256'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_hash_done"}, 256'(hash_done), 256'(0));
        chk({tag, "_err"}, 256'(err), 256'(0));
        chk({tag, "_enable"}, 256'(hif.hmac_enable), 256'(0));
        chk({tag, "_data_zero"}, 256'(hif.hmac_data == '0), 256'(1));
        chk({tag, "_hash_zero"}, 256'(hash == '0), 256'(1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int l [4];
        for (int i = 0; i < 4; i++) lat_arr[i] = 0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Fixed latency 10, all-zero inputs
        do_start('0, '0, 10, 10, 10, 10, t);
        wait_idle(2000);
        chk("l10_latency", 256'(last_evt_cyc - t), 256'(48));

        // Randomised derivations, occasional hung core
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++)
                l[i] = ($urandom_range(0, 9) == 0) ? HANG : int'($urandom_range(0, 15));
            do_start(rand640(), rand640(), l[0], l[1], l[2], l[3], t);
            wait_idle(2000);
        end

        // Boundary latency: done on the last counted cycle still completes
        do_start(rand640(), rand640(), 15, 0, 15, 1, t);
        wait_idle(2000);

        // Start during block 2 is ignored and busy stays high
        do_start(rand640(), rand640(), 10, 10, 10, 10, t);
        wait_block(2);
        start = 1'b1;
        pass  = rand640();
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("busy_during_ignored_start", 256'(busy), 256'(1));
        end
        wait_idle(2000);

        // Core never answers: error after the timeout window, then a clean restart
        do_start(rand640(), rand640(), HANG, HANG, HANG, HANG, t);
        wait_idle(2000);
        chk("timeout_latency", 256'(last_evt_cyc - t), 256'(17));
        do_start(rand640(), rand640(), 3, 7, 2, 9, t);
        wait_idle(2000);

        // Reset while the third block runs
        do_start(rand640(), rand640(), 10, 10, 10, 10, t);
        wait_block(3);
        n_rst = 1'b0;
        sbq.delete();
        @(negedge clk);
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        do_start(rand640(), rand640(), 4, 4, 4, 4, t);
        wait_idle(2000);

        // Stray core done in every GAP, then in DONE
        do_start(rand640(), rand640(), 5, 6, 7, 8, t);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            spur = busy && !hif.hmac_enable;
            if (sbq.size() == 0 && !busy) break;
        end
        spur = 1'b0;
        @(posedge clk);
        #1;
        spur = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("spur_done_held", 256'(hash_done), 256'(1));
            chk("spur_busy_low", 256'(busy), 256'(0));
            for (int b = 0; b < NB; b++)
                chk($sformatf("spur_slot%0d", b), hash[1023-256*b -: 256],
                    last_exp_hash[1023-256*b -: 256]);
        end
        @(posedge clk);
        #1;
        spur = 1'b0;

        // Back-to-back start from DONE
        do_start(rand640(), rand640(), 1, 0, 2, 0, t);
        wait_idle(2000);
        chk("scoreboard_drained", 256'(sbq.size()), 256'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
